traffic_light_ctrl: RTL and testbench

- Moore FSM driving one vehicle traffic light (red/yellow/green) plus a pedestrian walk signal.
- Sits directly downstream of counter_mod_k_ro: its roll_over output drives this block's tick input, so each phase duration is expressed in ticks rather than clock cycles.
- Pedestrian requests are latched and shorten the green phase once a minimum green time has elapsed.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/traffic_light_ctrl_if.sv | 20 ++
 rtl/phase_timer.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 93 +++++++++
 tb/tb_traffic_light_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding and duration helpers for traffic_light_ctrl
package traffic_pkg;

    typedef enum logic [1:0] {
        RED        = 2'd0,
        RED_YELLOW = 2'd1,
        GREEN      = 2'd2,
        YELLOW     = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            RED:        return RED_YELLOW;
            RED_YELLOW: return GREEN;
            GREEN:      return YELLOW;
            default:    return RED;
        endcase
    endfunction

    // Durations are passed in so each instance can carry its own parameter set.
    function automatic int unsigned phase_dur(
        input phase_t      p,
        input int unsigned t_red,
        input int unsigned t_red_yellow,
        input int unsigned t_green,
        input int unsigned t_yellow
    );
        case (p)
            RED:        return t_red;
            RED_YELLOW: return t_red_yellow;
            GREEN:      return t_green;
            default:    return t_yellow;
        endcase
    endfunction

    function automatic bit dur_ok(input int unsigned d, input int unsigned w);
        return (d >= 1) && (d < (32'd1 << w));
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - tick/request inputs and lamp outputs of the light controller
interface traffic_light_ctrl_if;
    logic       tick;
    logic       ped_req;
    logic       red;
    logic       yellow;
    logic       green;
    logic       ped_walk;
    logic [1:0] state_o;

    modport master (
        output tick, ped_req,
        input  red, yellow, green, ped_walk, state_o
    );

    modport slave (
        input  tick, ped_req,
        output red, yellow, green, ped_walk, state_o
    );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-gated in-phase counter with clear/load and terminal-count flag
module phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         done
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = (cnt == (limit - W'(1)));

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - Moore traffic light FSM with latched pedestrian requests
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned W            = 4,
    parameter int unsigned T_RED        = 4,
    parameter int unsigned T_RED_YELLOW = 1,
    parameter int unsigned T_GREEN      = 4,
    parameter int unsigned T_GREEN_MIN  = 2,
    parameter int unsigned T_YELLOW     = 2
) (
    input logic                 clk,
    input logic                 reset,
    traffic_light_ctrl_if.slave bus
);

    localparam logic [W-1:0] GREEN_MIN_M1 = W'(T_GREEN_MIN - 1);
    localparam bit DUR_OK = dur_ok(T_RED, W) && dur_ok(T_RED_YELLOW, W) &&
                            dur_ok(T_GREEN, W) && dur_ok(T_GREEN_MIN, W) &&
                            dur_ok(T_YELLOW, W) && (T_GREEN_MIN <= T_GREEN);

    phase_t       state_q, state_d;
    logic         ped_pending_q, ped_pending_d;
    logic         walk_flag_q, walk_flag_d;
    logic [W-1:0] cnt;
    logic [W-1:0] limit;
    logic         done;
    logic         advance;
    logic         early_exit;

    assign limit = W'(phase_dur(state_q, T_RED, T_RED_YELLOW, T_GREEN, T_YELLOW));

    phase_timer #(.W(W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (bus.tick),
        .clear    (advance),
        .load     (1'b0),
        .load_val ('0),
        .limit    (limit),
        .cnt      (cnt),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RED;
            ped_pending_q <= 1'b0;
            walk_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_flag_q   <= walk_flag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ped_pending_d = ped_pending_q;
        walk_flag_d   = walk_flag_q;
        advance       = 1'b0;
        early_exit    = (state_q == GREEN) && ped_pending_q && (cnt >= GREEN_MIN_M1);

        if (bus.tick && (done || early_exit)) begin
            advance = 1'b1;
            state_d = next_phase(state_q);
        end

        // A request seen while the current RED already shows walk is being served now.
        if (bus.ped_req && !((state_q == RED) && walk_flag_q)) begin
            ped_pending_d = 1'b1;
        end

        if (advance && (state_d == RED)) begin
            ped_pending_d = 1'b0;
            walk_flag_d   = ped_pending_q || bus.ped_req;
        end else if (advance && (state_q == RED)) begin
            walk_flag_d   = 1'b0;
        end
    end

    assign bus.red      = (state_q == RED) || (state_q == RED_YELLOW);
    assign bus.yellow   = (state_q == RED_YELLOW) || (state_q == YELLOW);
    assign bus.green    = (state_q == GREEN);
    assign bus.ped_walk = (state_q == RED) && walk_flag_q;
    assign bus.state_o  = state_q;

    always_ff @(posedge clk) begin
        assert (DUR_OK)
            else $error("traffic_light_ctrl: phase duration outside 1..2^W-1 or T_GREEN_MIN > T_GREEN");
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - scoreboard bench for traffic_light_ctrl driven by a mod-4 tick counter
module tb_traffic_light_ctrl;

    localparam int T_RED        = 4;
    localparam int T_RED_YELLOW = 1;
    localparam int T_GREEN      = 4;
    localparam int T_GREEN_MIN  = 2;
    localparam int T_YELLOW     = 2;
    localparam int K            = 4;

    localparam logic [1:0] S_RED = 2'd0;
    localparam logic [1:0] S_RY  = 2'd1;
    localparam logic [1:0] S_G   = 2'd2;
    localparam logic [1:0] S_Y   = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_en = 1'b1;
    logic [1:0] kcnt;
    logic roll_over;

    int tests_run = 0;
    int tests_failed = 0;

    logic [5:0] sb[$];

    traffic_light_ctrl_if bus();

    traffic_light_ctrl #(
        .W(4), .T_RED(T_RED), .T_RED_YELLOW(T_RED_YELLOW), .T_GREEN(T_GREEN),
        .T_GREEN_MIN(T_GREEN_MIN), .T_YELLOW(T_YELLOW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset) kcnt <= '0;
        else       kcnt <= (kcnt == 2'(K - 1)) ? 2'd0 : kcnt + 2'd1;
    end
    assign roll_over = (kcnt == 2'(K - 1));
    assign bus.tick  = roll_over && tick_en;

    function automatic logic [5:0] exp_vec(input logic [1:0] st, input logic walk);
        return {(st == S_RED) || (st == S_RY), (st == S_RY) || (st == S_Y),
                (st == S_G), (st == S_RED) && walk, st};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.state_o};
    endfunction

    task automatic push_n(input logic [1:0] st, input logic walk, input int n);
        for (int j = 0; j < n; j++) sb.push_back(exp_vec(st, walk));
    endtask

    // Expected post-tick outputs for one round starting at RED with cnt=0.
    task automatic gen_cycle(input logic walk_red, input logic early, input logic walk_end);
        push_n(S_RED, walk_red, T_RED - 1);
        push_n(S_RY, 1'b0, 1);
        push_n(S_RY, 1'b0, T_RED_YELLOW - 1);
        push_n(S_G, 1'b0, 1);
        push_n(S_G, 1'b0, (early ? T_GREEN_MIN : T_GREEN) - 1);
        push_n(S_Y, 1'b0, 1);
        push_n(S_Y, 1'b0, T_YELLOW - 1);
        push_n(S_RED, walk_end, 1);
    endtask

    task automatic drive_tick(input logic ped);
        bit found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus.tick) begin
                bus.ped_req = ped;
                @(posedge clk);
                #1;
                bus.ped_req = 1'b0;
                found = 1'b1;
            end
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL tick_timeout: got no tick, want one within 16 cycles");
        end
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp = exp_vec(S_RED, 1'b0);
        tests_run++;
        if (obs_vec() !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %b want %b", obs_vec(), exp);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_cycle();
        logic [5:0] exp;
        int n;
        gen_cycle(1'b0, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            drive_tick(1'b0);
            exp = sb.pop_front();
            tests_run++;
            if (obs_vec() !== exp) begin
                tests_failed++;
                $display("FAIL full_cycle tick %0d: got %b want %b", i + 1, obs_vec(), exp);
            end
        end
    endtask

    task automatic test_ped_green();
        logic [5:0] exp;
        int n;
        gen_cycle(1'b0, 1'b1, 1'b1);
        gen_cycle(1'b1, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            drive_tick(i == 4);
            exp = sb.pop_front();
            tests_run++;
            if (obs_vec() !== exp) begin
                tests_failed++;
                $display("FAIL ped_green tick %0d: got %b want %b", i + 1, obs_vec(), exp);
            end
        end
    endtask

    task automatic test_ped_red_entry();
        logic [5:0] exp;
        int n;
        gen_cycle(1'b0, 1'b0, 1'b1);
        gen_cycle(1'b1, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            drive_tick(i == 10);
            exp = sb.pop_front();
            tests_run++;
            if (obs_vec() !== exp) begin
                tests_failed++;
                $display("FAIL ped_red_entry tick %0d: got %b want %b", i + 1, obs_vec(), exp);
            end
        end
    endtask

    task automatic test_tick_hold();
        logic [5:0] exp;
        int n;
        gen_cycle(1'b0, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 6) begin
                @(negedge clk);
                tick_en = 1'b0;
                exp = exp_vec(S_G, 1'b0);
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    tests_run++;
                    if (obs_vec() !== exp) begin
                        tests_failed++;
                        $display("FAIL tick_hold cycle %0d: got %b want %b", c, obs_vec(), exp);
                    end
                end
                tick_en = 1'b1;
            end
            drive_tick(1'b0);
            exp = sb.pop_front();
            tests_run++;
            if (obs_vec() !== exp) begin
                tests_failed++;
                $display("FAIL tick_hold tick %0d: got %b want %b", i + 1, obs_vec(), exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        int n;
        gen_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_tick(i == 5);
            exp = sb.pop_front();
            tests_run++;
            if (obs_vec() !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid pre tick %0d: got %b want %b", i + 1, obs_vec(), exp);
            end
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp = exp_vec(S_RED, 1'b0);
        tests_run++;
        if (obs_vec() !== exp) begin
            tests_failed++;
            $display("FAIL reset_mid state: got %b want %b", obs_vec(), exp);
        end
        @(negedge clk);
        reset = 1'b0;
        gen_cycle(1'b0, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            drive_tick(1'b0);
            exp = sb.pop_front();
            tests_run++;
            if (obs_vec() !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid post tick %0d: got %b want %b", i + 1, obs_vec(), exp);
            end
        end
    endtask

    initial begin
        bus.ped_req = 1'b0;
        test_reset();
        test_full_cycle();
        test_ped_green();
        test_ped_red_entry();
        test_tick_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
